// File: rtl/cpu_bus_pkg.sv
// Shared command codes, FSM states and default widths for the CPU<->cache bus master.
package cpu_bus_pkg;

  localparam int A1_W_DEF           = 15;
  localparam int D1_W_DEF           = 16;
  localparam int C1_W_DEF           = 4;
  localparam int OFFSET_W_DEF       = 5;
  localparam int FIFO_DEPTH_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1023;

  typedef enum logic [2:0] {
    C1_NOP             = 3'd0,
    C1_READ8           = 3'd1,
    C1_READ16          = 3'd2,
    C1_READ32          = 3'd3,
    C1_INVALIDATE_LINE = 3'd4,
    C1_WRITE8          = 3'd5,
    C1_WRITE16         = 3'd6,
    C1_WRITE32         = 3'd7
  } c1_cmd_e;

  // The slave answers with the same code the master uses for WRITE32; the
  // master only ever samples C1 while it has released the bus.
  localparam logic [2:0] C1_RESPONSE = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD1  = 3'd1,
    ST_CMD2  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_BEAT2 = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  function automatic logic is_write(input logic [2:0] cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

endpackage

// File: rtl/cpu_bus_master_req_fifo.sv
// Request queue: synchronous FIFO, registered full/empty, head visible on pop_data.
// Push is ignored when full and pop is ignored when empty; no bypass path.
module req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  // Extra pointer bit distinguishes a wrapped (full) queue from an empty one.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/cpu_bus_master.sv
// CPU-side bus master: queued requests -> CMD1/CMD2 address phases -> WAIT -> one response each.
// Optional macro TIMEOUT_EN adds a WAIT watchdog that completes the request with rsp_err=1.
module cpu_bus_master
  import cpu_bus_pkg::*;
#(
  parameter int A1_W           = A1_W_DEF,
  parameter int D1_W           = D1_W_DEF,
  parameter int C1_W           = C1_W_DEF,
  parameter int OFFSET_W       = OFFSET_W_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [2:0]                 req_cmd,
  input  logic [A1_W+OFFSET_W-1:0]   req_addr,
  input  logic [2*D1_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2:0]                 rsp_cmd,
  output logic [2*D1_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic [A1_W-1:0]            A1,
  inout  wire  [D1_W-1:0]            D1,
  inout  wire  [C1_W-1:0]            C1
);

  localparam int ADDR_W = A1_W + OFFSET_W;
  localparam int W      = 2 * D1_W;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("cpu_bus_master: FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
    $error("cpu_bus_master: TIMEOUT_CYCLES must be >= 1");
  end

  typedef struct packed {
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      wdata;
  } req_t;

  req_t   push_ent;
  req_t   head;
  req_t   cur;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;
  state_e state;
  state_e state_nxt;

  logic [W-1:0]      rdata_q;
  logic              err_q;
  logic              bus_en;
  logic              c1_oe;
  logic              d1_oe;
  logic [C1_W-1:0]   c1_out;
  logic [D1_W-1:0]   d1_out;
  logic              rsp_hit;
  logic              timeout;

  assign push_ent  = '{cmd: req_cmd, addr: req_addr, wdata: req_wdata};
  assign req_ready = !fifo_full;

  req_fifo #(
    .WIDTH (3 + ADDR_W + W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (req_valid),
    .push_data (push_ent),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // An X/Z bus compares as unknown and falls through every if as "no response".
  assign rsp_hit = (C1 == C1_W'(C1_RESPONSE));

`ifdef TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                wait_cnt <= '0;
    else if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
    else                       wait_cnt <= '0;
  end

  assign timeout = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    c1_oe     = 1'b0;
    d1_oe     = 1'b0;
    c1_out    = C1_W'(C1_NOP);
    d1_out    = '0;
    A1        = '0;
    case (state)
      ST_IDLE: begin
        c1_oe = 1'b1;
        if (!fifo_empty && !rsp_valid) begin
          pop       = 1'b1;
          state_nxt = ST_CMD1;
        end
      end
      ST_CMD1: begin
        A1        = cur.addr[ADDR_W-1:OFFSET_W];
        c1_oe     = 1'b1;
        c1_out    = C1_W'(cur.cmd);
        d1_oe     = is_write(cur.cmd);
        d1_out    = cur.wdata[D1_W-1:0];
        state_nxt = ST_CMD2;
      end
      ST_CMD2: begin
        A1        = cur.addr[A1_W-1:0];
        c1_oe     = 1'b1;
        c1_out    = C1_W'(cur.cmd);
        d1_oe     = is_write(cur.cmd);
        d1_out    = (cur.cmd == C1_WRITE32) ? cur.wdata[W-1:D1_W] : cur.wdata[D1_W-1:0];
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (rsp_hit)      state_nxt = (cur.cmd == C1_READ32) ? ST_BEAT2 : ST_RESP;
        else if (timeout) state_nxt = ST_RESP;
      end
      ST_BEAT2: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur       <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      bus_en    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_cmd   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      bus_en <= 1'b1;
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cur     <= head;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (rsp_hit) begin
            case (cur.cmd)
              C1_READ8:  rdata_q <= W'(D1[7:0]);
              C1_READ16: rdata_q <= W'(D1);
              C1_READ32: rdata_q <= W'(D1);
              default:   rdata_q <= '0;
            endcase
          end else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        ST_BEAT2: rdata_q[W-1:D1_W] <= D1;
        ST_RESP: begin
          rsp_valid <= 1'b1;
          rsp_cmd   <= cur.cmd;
          rsp_rdata <= rdata_q;
          rsp_err   <= err_q;
        end
        default: ;
      endcase
    end
  end

  // bus_en keeps both buses floating throughout reset and until the first clock after it.
  assign C1 = (bus_en && c1_oe) ? c1_out : {C1_W{1'bz}};
  assign D1 = (bus_en && d1_oe) ? d1_out : {D1_W{1'bz}};

endmodule

// File: tb/tb_cpu_bus_master.sv
// Randomized bench for cpu_bus_master: queue-based request/response model plus a bus slave.
module tb_cpu_bus_master;
  import cpu_bus_pkg::*;

  localparam int A1_W = 15, D1_W = 16, C1_W = 4, OFFSET_W = 5, FIFO_DEPTH = 4, TO_CYC = 16;
  localparam int AW = A1_W + OFFSET_W;

  typedef struct packed { logic [2:0] cmd; logic [AW-1:0] addr; logic [31:0] wdata; } breq_t;
  typedef struct packed { logic [2:0] cmd; logic [31:0] rdata; logic err; } brsp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_cmd = '0;
  logic [AW-1:0]   req_addr = '0;
  logic [31:0]     req_wdata = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [2:0]      rsp_cmd;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic [A1_W-1:0] A1;
  wire  [D1_W-1:0] D1;
  wire  [C1_W-1:0] C1;

  logic            s_c1_oe = 1'b0, s_d1_oe = 1'b0;
  logic [C1_W-1:0] s_c1 = '0;
  logic [D1_W-1:0] s_d1 = '0;
  assign C1 = s_c1_oe ? s_c1 : {C1_W{1'bz}};
  assign D1 = s_d1_oe ? s_d1 : {D1_W{1'bz}};

  int n_checks = 0, n_errors = 0, n_push = 0, n_rsp = 0, flush_gen = 0;
  int rdy_mode = 0, slave_delay = 0;
  bit slave_rand = 0, slave_silent = 0, slave_busy = 0, beat_fix = 0;
  logic [15:0] fix_b0 = '0, fix_b1 = '0;
  breq_t bus_q[$];
  brsp_t rsp_q[$];

  cpu_bus_master #(
    .A1_W(A1_W), .D1_W(D1_W), .C1_W(C1_W), .OFFSET_W(OFFSET_W),
    .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_cmd(rsp_cmd),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .A1(A1), .D1(D1), .C1(C1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_wr(input logic [2:0] c);
    return c >= 3'd5;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [2:0] c, input logic [15:0] b0,
                                              input logic [15:0] b1);
    case (c)
      3'd1:    return 32'(b0 % 256);
      3'd2:    return 32'(b0);
      3'd3:    return 32'(b1) * 65536 + 32'(b0);
      default: return 32'd0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge, valid still high.
  task automatic push(input logic [2:0] c, input logic [AW-1:0] a, input logic [31:0] w);
    int n = 0;
    req_valid = 1'b1; req_cmd = c; req_addr = a; req_wdata = w;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    if (!req_ready) check("push_timeout", 32'(req_ready), 32'd1);
    else begin
      bus_q.push_back('{cmd: c, addr: a, wdata: w});
      n_push++;
    end
    @(negedge clk);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((bus_q.size() != 0 || rsp_q.size() != 0 || rsp_valid || slave_busy) && n < 3000) begin
      @(negedge clk); n++;
    end
    check(tag, 32'(n < 3000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : slave
    breq_t r;
    int gen, d;
    logic [15:0] b0, b1;
    forever begin
      slave_busy = 0;
      @(negedge clk);
      if (reset && (C1 != 4'd0)) begin
        slave_busy = 1;
        gen = flush_gen;
        if (bus_q.size() == 0) begin check("bus_unexpected_cmd", 32'(C1), 32'd0); continue; end
        r = bus_q.pop_front();
        check("cmd1_c1", 32'(C1), 32'(r.cmd));
        check("cmd1_a1", 32'(A1), 32'(r.addr) / 32'(1 << OFFSET_W));
        if (is_wr(r.cmd)) check("cmd1_d1", 32'(D1), r.wdata % 65536);
        @(negedge clk);
        if (gen != flush_gen) continue;
        check("cmd2_c1", 32'(C1), 32'(r.cmd));
        check("cmd2_a1", 32'(A1), 32'(r.addr) % 32'(1 << A1_W));
        if (is_wr(r.cmd)) check("cmd2_d1", 32'(D1), (r.cmd == 3'd7) ? r.wdata / 65536 : r.wdata % 65536);
        @(negedge clk);
        d = slave_rand ? int'($urandom_range(0, 3)) : slave_delay;
        repeat (d) @(negedge clk);
        while (slave_silent && gen == flush_gen) @(negedge clk);
        if (gen != flush_gen) continue;
        b0 = beat_fix ? fix_b0 : 16'($urandom);
        b1 = beat_fix ? fix_b1 : 16'($urandom);
        rsp_q.push_back('{cmd: r.cmd, rdata: model_rdata(r.cmd, b0, b1), err: 1'b0});
        s_c1 = C1_W'(C1_RESPONSE); s_c1_oe = 1'b1; s_d1 = b0; s_d1_oe = 1'b1;
        @(negedge clk);
        s_c1_oe = 1'b0;
        if (r.cmd == 3'd3) begin s_d1 = b1; @(negedge clk); end
        s_d1_oe = 1'b0;
      end
    end
  end

  initial begin : rsp_mon
    brsp_t e;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
      if (reset && rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          e = rsp_q.pop_front();
          check("rsp_cmd", 32'(rsp_cmd), 32'(e.cmd));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          n_rsp++;
        end
      end
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no completion expected finish within 60000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_cmd", 32'(rsp_cmd), 32'd0);
    check("rst_a1", 32'(A1), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_c1_nop", 32'(C1), 32'd0);

    // WRITE32 with a 3-cycle slave
    rdy_mode = 0; slave_delay = 3;
    push(3'd7, 20'h00200, 32'hDEADBEEF); req_valid = 1'b0;
    wait_rsp(n); check("wr32_latency", 32'(n), 32'd8);
    drain("wr32_drain");

    // READ32 with zero-wait slave
    beat_fix = 1; fix_b0 = 16'h0003; fix_b1 = 16'h0000; slave_delay = 0;
    push(3'd3, 20'h00400, 32'h0); req_valid = 1'b0;
    wait_rsp(n); check("rd32_latency", 32'(n), 32'd6); check("rd32_data", rsp_rdata, 32'h3);
    drain("rd32_drain");

    fix_b0 = 16'hA5C3;
    push(3'd1, 20'h00001, 32'h0); req_valid = 1'b0;
    wait_rsp(n); check("rd8_latency", 32'(n), 32'd5); check("rd8_data", rsp_rdata, 32'hC3);
    drain("rd8_drain");
    push(3'd2, 20'h00001, 32'h0); req_valid = 1'b0;
    wait_rsp(n); check("rd16_data", rsp_rdata, 32'hA5C3);
    drain("rd16_drain");
    beat_fix = 0;

    // A held response blocks the next issue
    rdy_mode = 2;
    push(3'd5, 20'h12345, 32'h11223344); push(3'd6, 20'h0ABCD, 32'h55667788); req_valid = 1'b0;
    wait_rsp(n);
    repeat (6) @(negedge clk);
    check("held_rsp_valid", 32'(rsp_valid), 32'd1);
    check("held_no_issue_c1", 32'(C1), 32'd0);
    rdy_mode = 0;
    drain("held_drain");

    // Silent slave: one in WAIT, four queued, sixth refused
    slave_silent = 1;
    for (int i = 0; i < 5; i++) push(3'($urandom_range(1, 7)), AW'($urandom), $urandom);
    req_cmd = 3'd4;
    check("full_req_ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("full_req_ready_hold", 32'(req_ready), 32'd0);
    check("full_no_rsp", 32'(rsp_valid), 32'd0);
    slave_silent = 0;
    push(3'd4, AW'($urandom), 32'h0); req_valid = 1'b0;
    drain("full_drain");

`ifdef TIMEOUT_EN
    slave_silent = 1;
    rsp_q.push_back('{cmd: 3'd2, rdata: 32'd0, err: 1'b1});
    push(3'd2, 20'h00040, 32'h0); req_valid = 1'b0;
    wait_rsp(n); check("to_latency", 32'(n), 32'd20);
    check("to_err", 32'(rsp_err), 32'd1);
    check("to_c1_nop", 32'(C1), 32'd0);
    flush_gen++; slave_silent = 0;
    drain("to_drain");
`endif

    // Reset during WAIT with two queued
    slave_silent = 1;
    for (int i = 0; i < 3; i++) push(3'($urandom_range(1, 7)), AW'($urandom), $urandom);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_a1", 32'(A1), 32'd0);
    bus_q.delete(); rsp_q.delete(); flush_gen++; slave_silent = 0;
    n_push -= 3;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_c1_nop", 32'(C1), 32'd0);
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Random traffic
    slave_rand = 1;
    for (int i = 0; i < 150; i++) begin
      rdy_mode = (i < 50) ? 1 : (i < 100) ? 0 : 1;
      if ($urandom_range(0, 3) == 0) begin req_valid = 1'b0; @(negedge clk); end
      push(3'($urandom_range(1, 7)), AW'($urandom), $urandom);
    end
    req_valid = 1'b0;
    rdy_mode = 1;
    drain("rand_drain");

    check("bus_q_left", 32'(bus_q.size()), 32'd0);
    check("rsp_q_left", 32'(rsp_q.size()), 32'd0);
    check("rsp_count", 32'(n_rsp), 32'(n_push));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
Synthesizable, parametrised CPU-side master for the CPU↔cache bus (A1/D1/C1).
- Accepts queued requests (READ8/16/32, WRITE8/16/32, INVALIDATE_LINE) on a valid/ready interface.
- Serialises each request into the two-phase address protocol with two-beat 32-bit transfers.
- Returns one response per request on a valid/ready interface.
- Replaces the behavioural stimulus CPU; lets traffic generators drive the cache at full rate.

Parameters:
A1_W, 15, A1 width (tag+set bits)
D1_W, 16, D1 width; one beat
C1_W, 4, C1 width
OFFSET_W, 5, line offset bits; request address width is A1_W+OFFSET_W
FIFO_DEPTH, 4, request queue entries (power of 2, ≥2)
TIMEOUT_CYCLES, 1023, WAIT cycles before error (used only with TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request offered
req_ready  out  1  queue not full
req_cmd  in  3  C1_* command code (1..7)
req_addr  in  A1_W+OFFSET_W  byte address
req_wdata  in  2*D1_W  write data, low half sent first
rsp_valid  out  1  response held
rsp_ready  in  1  response consumed
rsp_cmd  out  3  command of completed request
rsp_rdata  out  2*D1_W  read data, zero-extended; 0 for writes/invalidate
rsp_err  out  1  timeout (0 when TIMEOUT_EN undefined)
A1  out  A1_W  bus address
D1  inout  D1_W  bus data, tristate
C1  inout  C1_W  bus control, tristate

Behaviour:
- Reset (reset=0, async): FSM=IDLE, FIFO flushed, rsp_valid=0, rsp_err=0, rsp_rdata=0, rsp_cmd=0, A1=0, D1/C1 drive disabled (Z).
- Push: req_valid&&req_ready at posedge. req_ready=!full only; no bypass when full, even with same-cycle pop.
- FSM states:
  - IDLE: drive C1=C1_NOP, D1=Z. Issue when FIFO non-empty && rsp_valid==0 at posedge: pop, go CMD1.
  - CMD1: A1=addr>>OFFSET_W, C1=cmd. D1=wdata[D1_W-1:0] for writes, else Z. Next CMD2.
  - CMD2: A1=addr[A1_W-1:0], C1=cmd. D1=wdata[2*D1_W-1:D1_W] for WRITE32, low half for WRITE8/16, Z otherwise. Next WAIT.
  - WAIT: C1/D1 released. Sample C1 each posedge. On C1==C1_RESPONSE (7):
    - capture D1;
    - READ8 → rdata={0,D1[7:0]}; READ16 → {0,D1};
    - READ32 → store low half, go BEAT2;
    - all others → rdata=0, go RESP.
  - BEAT2: capture D1 as high half at next posedge, go RESP.
  - RESP: load rsp_* registers, rsp_valid=1; C1/D1 stay Z (turnaround). Next IDLE.
- C1 is sampled only while released. C1_WRITE32 and C1_RESPONSE share code 7, so no ambiguity arises.
- rsp_valid stays high until rsp_valid&&rsp_ready at a posedge. A new issue needs rsp_valid==0 at the edge, so there is one bubble after the handshake.
- Latency with a zero-wait slave and an empty FIFO: push at edge0 → CMD1 after edge1 → CMD2 after edge2 → WAIT after edge3 → response at edge4 → RESP → rsp_valid after edge5 (edge6 for READ32).
- X/Z on C1 during WAIT is treated as not-response.
- Mid-transaction async reset aborts with no response generated.

Optional Feature:
- Macro TIMEOUT_EN.
- Defined: WAIT counter starts at 0 on entry. At TIMEOUT_CYCLES without response, go RESP with rsp_err=1, rsp_rdata=0, rsp_cmd=original. Counter resets per transaction.
- Undefined: no counter; WAIT forever; rsp_err tied 0.

Decomposition:
- Package cpu_bus_pkg:
  - C1 enum (NOP=0, READ8=1, READ16=2, READ32=3, INVALIDATE_LINE=4, WRITE8=5, WRITE16=6, WRITE32=7);
  - C1_RESPONSE=7;
  - default width constants;
  - FSM state typedef.
- Sub-module req_fifo: synchronous FIFO, async active-low reset, width 3+A1_W+OFFSET_W+2*D1_W, depth FIFO_DEPTH, full/empty flags.

Test Plan:
1. WRITE32 addr 0x00200 data 0xDEADBEEF → CMD1: A1=0x010, C1=7, D1=0xBEEF; CMD2: A1=0x0200, D1=0xDEAD; slave responds 3 cycles later → rsp_valid, rsp_cmd=7, rsp_rdata=0, rsp_err=0.
2. READ32 addr 0x00400, slave beats 0x0003 then 0x0000 → rsp_rdata=0x00000003; zero-wait slave gives rsp_valid 6 edges after push.
3. READ8 addr 0x00001, slave D1=0xA5C3 → rsp_rdata=0x000000C3; READ16 same → 0x0000A5C3.
4. Slave silent, rsp_ready=0, push 6 requests → first issued and stuck in WAIT, 4 queued, req_ready=0 on 6th until progress.
5. TIMEOUT_EN, TIMEOUT_CYCLES=16, silent slave → after 16 WAIT edges rsp_err=1, rsp_rdata=0; C1=NOP one cycle after RESP.
6. Reset low during WAIT with 2 queued → immediately rsp_valid=0, req_ready=1, C1/D1=Z; after release, C1=NOP and no stale transaction is issued.
